// File: rtl/uart_rx_sniffer.sv
// ----------------------------------------------------------------------------
// uart_rx_sniffer
//
// Host-side UART receiver. Deserialises frames from the peripheral tx line,
// LSB first, and buffers the bytes in a small first-word-fall-through FIFO
// that is drained through a valid/ready byte stream.
//
// Build option:
//   UART_RX_PARITY_EN  undefined: 8N1 frames.
//                      defined:   8E1 frames; a parity mismatch discards the
//                                 byte and pulses frame_err_o.
//
// Parameters:
//   CLK_DIV     clk_i cycles per UART bit (even, >= 4)
//   FIFO_DEPTH  byte FIFO entries (power of two, >= 2)
//
// Ports:
//   clk_i         sole clock
//   rst_i         synchronous, active-high reset
//   rx_i          serial line, idle high, asynchronous to clk_i
//   byte_o        FIFO head byte (0 after reset)
//   byte_valid_o  FIFO not empty
//   byte_ready_i  consumer takes byte_o this cycle
//   count_o       FIFO occupancy
//   frame_err_o   one-cycle pulse on a bad stop bit (or bad parity)
//   overflow_o    sticky: a byte was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module uart_rx_sniffer #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             rx_i,
    output logic [7:0]                       byte_o,
    output logic                             byte_valid_o,
    input  logic                             byte_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
    output logic                             frame_err_o,
    output logic                             overflow_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

    // Terminal divider values: a full bit, and half a bit to reach mid start bit.
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreak
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StStop, StBreak
    } state_e;
`endif

    // ------------------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx_s;
    logic w_fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_s = r_sync2;
    assign w_fall = r_rx_prev & ~r_sync2;

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    state_e           r_state;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             w_div_exp;
    logic             w_parity_ok;
    logic             w_push;

    assign w_div_exp = (r_state == StStart) ? (r_div == DIV_HALF) : (r_div == DIV_FULL);

`ifdef UART_RX_PARITY_EN
    logic r_par;
    // Even parity: data bits plus parity bit hold an even number of ones.
    assign w_parity_ok = (r_par == ^r_shift);
`else
    assign w_parity_ok = 1'b1;
`endif

    // A byte is pushed in the cycle the stop bit is sampled high.
    assign w_push = (r_state == StStop) & w_div_exp & w_rx_s & w_parity_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_div       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_fall) begin
                        r_state <= StStart;
                        r_div   <= '0;
                    end
                end
                StStart: begin
                    if (w_div_exp) begin
                        r_div <= '0;
                        if (!w_rx_s) begin
                            r_state <= StData;
                            r_idx   <= '0;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            r_state <= StIdle;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                StData: begin
                    if (w_div_exp) begin
                        r_div          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= StParity;
`else
                            r_state <= StStop;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (w_div_exp) begin
                        r_div   <= '0;
                        r_par   <= w_rx_s;
                        r_state <= StStop;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
`endif
                StStop: begin
                    if (w_div_exp) begin
                        r_div <= '0;
                        if (!w_rx_s) begin
                            // Low stop bit: report once, then wait out a held-low line.
                            r_frame_err <= 1'b1;
                            r_state     <= StBreak;
                        end else begin
                            r_frame_err <= ~w_parity_ok;
                            r_state     <= StIdle;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                StBreak: begin
                    if (w_rx_s) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign frame_err_o = r_frame_err;

    // ------------------------------------------------------------------------
    // Byte FIFO (first-word fall-through)
    // ------------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;

    assign w_pop  = byte_valid_o & byte_ready_i;
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign w_wr   = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= r_shift;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign byte_o       = r_mem[r_rptr];
    assign byte_valid_o = (r_count != '0);
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;

endmodule

// File: doc/uart_rx_sniffer.md
Name: uart_rx_sniffer

Overview:
Host-side UART receiver for the simulation harness. It consumes the serial `tx` line driven by the peripheral subsystem and deserialises 8N1 frames into bytes. Received bytes are buffered in a small first-word-fall-through FIFO and presented on a valid/ready byte stream, for the console logger and the exit-code decoder. This block replaces the behavioural UART bus model with synthesizable, checkable RTL.

Parameters:
- CLK_DIV, 16, clk_i cycles per UART bit; even, >= 4.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  sole clock.
- rst_i  input  1  synchronous, active-high reset.
- rx_i  input  1  serial line (idle high); asynchronous to clk_i.
- byte_o  output  8  FIFO head byte.
- byte_valid_o  output  1  FIFO not empty.
- byte_ready_i  input  1  consumer accepts byte_o this cycle.
- count_o  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overflow_o  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Interface (already decided): one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - byte_valid_o=0, count_o=0, frame_err_o=0, overflow_o=0, byte_o=0.
  - Synchroniser flops = 1; FSM = IDLE; bit counter and divider = 0.
- Synchroniser: 2-FF on rx_i, giving rx_s. All logic uses rx_s. Falling-edge detect compares rx_s against its previous value.
- Divider counts 0..CLK_DIV-1; width $clog2(CLK_DIV). Bit index is 3 bits.
- FSM:
  - IDLE: on a falling edge of rx_s, go to START and load the divider for CLK_DIV/2.
  - START: at divider expiry, sample rx_s.
    - 0: go to DATA, bit index=0, divider=CLK_DIV.
    - 1: glitch; return to IDLE with no output.
  - DATA: every CLK_DIV cycles, sample rx_s into shift register bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after CLK_DIV cycles, sample rx_s.
    - 1: push the byte; go to IDLE.
    - 0: pulse frame_err_o for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. A held-low line yields exactly one frame_err_o.
- Latency: byte_valid_o rises exactly 3 + CLK_DIV/2 + 9*CLK_DIV cycles after the first cycle rx_i is low (155 for CLK_DIV=16), assuming the FIFO was empty.
- FIFO:
  - First-word fall-through; pop when byte_valid_o & byte_ready_i.
  - Push while full and no pop: byte dropped, overflow_o set (held until rst_i), count_o unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: the byte is stored (not bypassed); count_o 0→1.
  - Pointers wrap modulo FIFO_DEPTH. Byte order is preserved.
- byte_o holds the head value while byte_valid_o=1 and not popped. byte_o is don't-care when empty, but driven to 0 from reset.
- Back-to-back frames: a new start edge is accepted from the cycle after STOP completes. No idle bit is required beyond the stop bit.
- rst_i mid-frame: the partial byte is discarded, the FIFO is cleared, and all sticky flags are cleared. The next falling edge starts a fresh frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP and samples 1 bit after CLK_DIV cycles.
  - Parity mismatch: the byte is discarded and frame_err_o pulses, in the STOP-sample cycle.
  - Latency grows by CLK_DIV (171 for CLK_DIV=16).
- Undefined: 8N1 only; no PARITY state exists.

Test Plan (CLK_DIV=16, FIFO_DEPTH=4):
- Send 0x55, then 0xA3, with byte_ready_i=1 → byte_o=0x55 valid exactly 155 cycles after the first start-bit low; then 0xA3. frame_err_o=0, overflow_o=0.
- Drive rx_i low for 4 cycles, then high → no byte, frame_err_o=0, FSM back in IDLE, count_o=0.
- Send 0x3C with stop bit 0, holding the line low for 40 cycles → exactly one frame_err_o pulse, count_o=0. A following 0x81 is received correctly.
- byte_ready_i=0; send 0x01..0x05 → count_o=4, overflow_o=1. Popping yields 0x01,0x02,0x03,0x04; 0x05 is lost.
- FIFO full; pop in the exact cycle a 0x7E push occurs → count_o stays 4, overflow_o stays 0, 0x7E is last out.
- Assert rst_i for 1 cycle midway through bit 3 of 0xF0; then send 0x0F → only 0x0F is delivered, all flags 0.
